// File: rtl/f1_pkg.sv
// Shared types and lamp constants for the F1 start-light controller.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEQ    = 3'd1,
        DELAY  = 3'd2,
        TIMING = 3'd3,
        DONE   = 3'd4
    } f1_state_e;

    localparam logic [7:0] LIGHTS_ALL = 8'hFF;
    localparam logic [7:0] LIGHTS_OFF = 8'h00;

endpackage

// File: rtl/f1_tick_gen.sv
// Free-running tick divider: pulses tick for one enabled cycle every TICK_CYCLES enabled cycles.
module f1_tick_gen #(
    parameter int TICK_CYCLES = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    // clear wins over en so the count always restarts from zero on a new phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer: lamp build-up, random hold, lamps-out and reaction timing.
// Optional macro F1_DELAY_MIN_EN: hold ticks become rnd + DELAY_MIN instead of rnd (0 -> 1).
module f1_start_ctrl
    import f1_pkg::*;
#(
    parameter int TICK_CYCLES = 50,
    parameter int RT_WIDTH    = 16,
    parameter int DELAY_MIN   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                react,
    input  logic [6:0]          rnd,
    output logic [7:0]          data_out,
    output logic                cmd_seq,
    output logic                cmd_delay,
    output logic                busy,
    output logic [RT_WIDTH-1:0] rt,
    output logic                rt_valid,
    output logic                jump_start,
    output logic [2:0]          state_dbg
);

    if (TICK_CYCLES < 2) begin : g_bad_tick_cycles
        $error("TICK_CYCLES must be at least 2");
    end
    if (DELAY_MIN < 0 || DELAY_MIN > 128) begin : g_bad_delay_min
        $error("DELAY_MIN must fit the 8-bit hold counter");
    end

    f1_state_e           state;
    logic                trig_prev;
    logic                react_prev;
    logic [7:0]          delay_cnt;
    logic [7:0]          delay_load;
    logic [RT_WIDTH-1:0] rt_cnt;
    logic                trig_edge;
    logic                react_edge;
    logic                timed_phase;
    logic                tick;

    assign trig_edge   = trigger & ~trig_prev;
    assign react_edge  = react & ~react_prev;
    assign timed_phase = (state == SEQ) || (state == DELAY);
    assign state_dbg   = state;

`ifdef F1_DELAY_MIN_EN
    assign delay_load = {1'b0, rnd} + 8'(DELAY_MIN);
`else
    assign delay_load = (rnd == 7'd0) ? 8'd1 : {1'b0, rnd};
`endif

    f1_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en && timed_phase),
        .clear(!timed_phase),
        .tick (tick)
    );

    // Everything, including the rt_valid pulse, freezes while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            trig_prev  <= 1'b0;
            react_prev <= 1'b0;
            delay_cnt  <= '0;
            rt_cnt     <= '0;
            data_out   <= LIGHTS_OFF;
            cmd_seq    <= 1'b0;
            cmd_delay  <= 1'b0;
            busy       <= 1'b0;
            rt         <= '0;
            rt_valid   <= 1'b0;
            jump_start <= 1'b0;
        end else if (en) begin
            trig_prev  <= trigger;
            react_prev <= react;
            rt_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        state      <= SEQ;
                        cmd_seq    <= 1'b1;
                        busy       <= 1'b1;
                        jump_start <= 1'b0;
                        data_out   <= LIGHTS_OFF;
                    end
                end
                SEQ, DELAY: begin
                    // an early react beats a coincident tick, even the last hold tick
                    if (react_edge) begin
                        state      <= DONE;
                        jump_start <= 1'b1;
                        data_out   <= LIGHTS_OFF;
                        cmd_seq    <= 1'b0;
                        cmd_delay  <= 1'b0;
                    end else if (tick && state == SEQ) begin
                        if (data_out == LIGHTS_ALL) begin
                            state     <= DELAY;
                            cmd_seq   <= 1'b0;
                            cmd_delay <= 1'b1;
                            delay_cnt <= delay_load;
                        end else begin
                            data_out <= {data_out[6:0], 1'b1};
                        end
                    end else if (tick) begin
                        if (delay_cnt == 8'd1) begin
                            state     <= TIMING;
                            cmd_delay <= 1'b0;
                            data_out  <= LIGHTS_OFF;
                            rt_cnt    <= '0;
                        end
                        delay_cnt <= delay_cnt - 8'd1;
                    end
                end
                TIMING: begin
                    if (react_edge) begin
                        rt       <= rt_cnt;
                        rt_valid <= 1'b1;
                        state    <= DONE;
                    end else if (rt_cnt == '1) begin
                        rt       <= '1;
                        rt_valid <= 1'b1;
                        state    <= DONE;
                    end else begin
                        rt_cnt <= rt_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_seq   <= 1'b0;
                    cmd_delay <= 1'b0;
                    data_out  <= LIGHTS_OFF;
                end
            endcase
        end
    end

endmodule
